core_pipe_fetch_mq: RTL and testbench

CORE_PIPE_FETCH_MQ -- requirements
Module: core_pipe_fetch_mq

---
 rtl/core_common_pkg.sv | 23 ++
 rtl/core_pipe_fetch_qbuf.sv | 94 +++++++++
 rtl/core_pipe_fetch_mq.sv | 120 ++++++++++++
 tb/tb_core_pipe_fetch_mq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/core_common_pkg.sv
// rtl/core_common_pkg.sv - shared memory-port widths and fetch configuration checks
//
// Purpose : widths of the core's instruction-memory port and legality
//           helpers for fetch-unit parameters.
// Contents: MEM_ADDR_W, MEM_DATA_W, MEM_STRB_W, fetch_bytes_legal(),
//           fetch_cfg_legal().
package core_common;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  function automatic bit fetch_bytes_legal(input int fetch_bytes);
    return (fetch_bytes == 4) || (fetch_bytes == 8);
  endfunction

  function automatic bit fetch_cfg_legal(input int fetch_bytes, input int max_out,
                                         input int buf_bytes);
    return fetch_bytes_legal(fetch_bytes) && (max_out >= 1) && (max_out <= 4) &&
           (buf_bytes >= 2 * fetch_bytes) && ((buf_bytes & (buf_bytes - 1)) == 0);
  endfunction

endpackage

// File: rtl/core_pipe_fetch_qbuf.sv
// rtl/core_pipe_fetch_qbuf.sv - halfword-granular fetch buffer with skip fill and 2/4 byte drain
//
// Purpose : holds fetched halfwords (each tagged with its bus error) in
//           order; slot 0 is the oldest. Empty slots are kept at zero so the
//           head reads zero where nothing is buffered yet.
// Ports   : g_clk, g_resetn      clock, synchronous active-low reset
//           flush                drop everything (overrides eat and fill)
//           fill/fill_data/fill_err/fill_skip
//                                append beat halfwords at index >= fill_skip
//           eat_2, eat_4         remove 2 or 4 bytes from the head
//           head_data/head_err   lowest 4 bytes and their halfword tags
//           depth, n_depth       current and next-cycle occupancy in bytes
module core_pipe_fetch_qbuf #(
  parameter int FETCH_BYTES = 8,
  parameter int BUF_BYTES   = 16
) (
  input  logic                               g_clk,
  input  logic                               g_resetn,
  input  logic                               flush,
  input  logic                               fill,
  input  logic [FETCH_BYTES*8-1:0]           fill_data,
  input  logic                               fill_err,
  input  logic [$clog2(FETCH_BYTES/2)-1:0]   fill_skip,
  input  logic                               eat_2,
  input  logic                               eat_4,
  output logic [31:0]                        head_data,
  output logic [1:0]                         head_err,
  output logic [$clog2(BUF_BYTES/2+1):0]     depth,
  output logic [$clog2(BUF_BYTES/2+1):0]     n_depth
);

  localparam int NH = BUF_BYTES / 2;
  localparam int FH = FETCH_BYTES / 2;
  localparam int CW = $clog2(NH + 1);
  localparam int HW = NH * 16;

  logic [HW-1:0] hw_q, hw_d, kept_hw, placed_hw;
  logic [NH-1:0] err_q, err_d, kept_err;
  logic [CW-1:0] cnt_q, cnt_d;
  int            drain, keep, fill_n;

  always_comb begin
    drain = 0;
    if (eat_4) drain = 2;
    else if (eat_2) drain = 1;
    keep      = int'(cnt_q) - drain;
    fill_n    = fill ? FH - int'(fill_skip) : 0;
    // Drain shifts the survivors down; the beat is pre-shifted so its first
    // wanted halfword lands directly above the survivors.
    kept_hw   = hw_q >> (16 * drain);
    kept_err  = err_q >> drain;
    placed_hw = HW'(fill_data >> (16 * int'(fill_skip))) << (16 * keep);
    hw_d      = '0;
    err_d     = '0;
    for (int i = 0; i < NH; i++) begin
      if (i < keep) begin
        hw_d[16*i +: 16] = kept_hw[16*i +: 16];
        err_d[i]         = kept_err[i];
      end else if (i < keep + fill_n) begin
        hw_d[16*i +: 16] = placed_hw[16*i +: 16];
        err_d[i]         = fill_err;
      end
    end
    cnt_d = CW'(keep + fill_n);
    if (flush) begin
      hw_d  = '0;
      err_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      hw_q  <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      hw_q  <= hw_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_data = hw_q[31:0];
  assign head_err  = err_q[1:0];
  assign depth     = {cnt_q, 1'b0};
  assign n_depth   = {cnt_d, 1'b0};

  a_eat_excl:    assert property (@(posedge g_clk) disable iff (!g_resetn) !(eat_2 && eat_4));
  a_eat_depth:   assert property (@(posedge g_clk) disable iff (!g_resetn) drain <= int'(cnt_q));
  a_no_overflow: assert property (@(posedge g_clk) disable iff (!g_resetn)
                                  flush || (keep + fill_n <= NH));

endmodule

// File: rtl/core_pipe_fetch_mq.sv
// rtl/core_pipe_fetch_mq.sv - instruction fetch with multiple outstanding requests
//
// Purpose : issues aligned fetch requests under a credit limit, drops
//           responses belonging to requests made before a control-flow
//           change, and presents the next 16/32-bit instruction.
// Ports   : g_clk, g_resetn                 clock, synchronous active-low reset
//           cf_valid/cf_ack/cf_target       control-flow change handshake
//           imem_req/imem_addr/imem_gnt     request channel
//           imem_wen/imem_strb/imem_wdata   unused write side, tied to zero
//           imem_rsp/imem_err/imem_rdata    in-order response channel
//           s1_i16bit/s1_i32bit/s1_instr/s1_ferr, s1_eat_2/s1_eat_4
//                                           decode-stage head and consume
module core_pipe_fetch_mq
  import core_common::*;
#(
  parameter logic [MEM_ADDR_W-1:0] PC_RESET_ADDRESS = 'h10000000,
  parameter int                    FETCH_BYTES      = 8,
  parameter int                    MAX_OUTSTANDING  = 2,
  parameter int                    BUF_BYTES        = 16
) (
  input  logic                     g_clk,
  input  logic                     g_resetn,
  input  logic                     cf_valid,
  output logic                     cf_ack,
  input  logic [MEM_ADDR_W-1:0]    cf_target,
  output logic                     imem_req,
  output logic [MEM_ADDR_W-1:0]    imem_addr,
  input  logic                     imem_gnt,
  output logic                     imem_wen,
  output logic [MEM_STRB_W-1:0]    imem_strb,
  output logic [MEM_DATA_W-1:0]    imem_wdata,
  input  logic                     imem_rsp,
  input  logic                     imem_err,
  input  logic [FETCH_BYTES*8-1:0] imem_rdata,
  output logic                     s1_i16bit,
  output logic                     s1_i32bit,
  output logic [31:0]              s1_instr,
  output logic [1:0]               s1_ferr,
  input  logic                     s1_eat_2,
  input  logic                     s1_eat_4
);

  localparam int LB = $clog2(FETCH_BYTES);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW = $clog2(BUF_BYTES / 2 + 1) + 1;

  logic [OW-1:0] outstanding, outst_next, drop_cnt;
  logic [LB-2:0] skip_off;
  logic [DW-1:0] depth, n_depth;
  logic          grant, cf_acc, fill, req_next;

  assign imem_wen   = 1'b0;
  assign imem_strb  = '0;
  assign imem_wdata = '0;

  assign grant      = imem_req && imem_gnt;
  assign cf_ack     = !imem_req || imem_gnt;
  assign cf_acc     = cf_valid && cf_ack;
  assign outst_next = outstanding + OW'(grant) - OW'(imem_rsp);
  assign fill       = imem_rsp && (drop_cnt == '0) && !cf_acc;

  // Credit check on post-cycle state: every granted beat plus the next one
  // must still fit beside what the buffer will hold.
  assign req_next = (int'(outst_next) < MAX_OUTSTANDING) &&
                    (int'(n_depth) + (int'(outst_next) + 1) * FETCH_BYTES <= BUF_BYTES);

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      imem_req    <= 1'b0;
      imem_addr   <= PC_RESET_ADDRESS;
      outstanding <= '0;
      drop_cnt    <= '0;
      skip_off    <= '0;
    end else begin
      outstanding <= outst_next;
      if (cf_acc) begin
        imem_addr <= {cf_target[MEM_ADDR_W-1:LB], {LB{1'b0}}};
        drop_cnt  <= outst_next;
        skip_off  <= cf_target[LB-1:1];
      end else begin
        if (grant) imem_addr <= imem_addr + MEM_ADDR_W'(FETCH_BYTES);
        if (imem_rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
        else if (imem_rsp) skip_off <= '0;
      end
      // An ungranted request is held; a cf cannot be accepted in that case.
      if (imem_req && !imem_gnt) imem_req <= 1'b1;
      else imem_req <= req_next;
    end
  end

  core_pipe_fetch_qbuf #(
    .FETCH_BYTES (FETCH_BYTES),
    .BUF_BYTES   (BUF_BYTES)
  ) u_qbuf (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (cf_acc),
    .fill      (fill),
    .fill_data (imem_rdata),
    .fill_err  (imem_err),
    .fill_skip (skip_off),
    .eat_2     (s1_eat_2),
    .eat_4     (s1_eat_4),
    .head_data (s1_instr),
    .head_err  (s1_ferr),
    .depth     (depth),
    .n_depth   (n_depth)
  );

  assign s1_i16bit = (depth >= DW'(2)) && (s1_instr[1:0] != 2'b11);
  assign s1_i32bit = (depth >= DW'(4)) && (s1_instr[1:0] == 2'b11);

  a_params:   assert property (@(posedge g_clk)
                fetch_cfg_legal(FETCH_BYTES, MAX_OUTSTANDING, BUF_BYTES));
  a_cf_align: assert property (@(posedge g_clk) disable iff (!g_resetn)
                cf_valid |-> !cf_target[0]);
  a_rsp_owed: assert property (@(posedge g_clk) disable iff (!g_resetn)
                imem_rsp |-> outstanding != '0);

endmodule

// File: tb/tb_core_pipe_fetch_mq.sv
// tb/tb_core_pipe_fetch_mq.sv - randomized scoreboard bench for core_pipe_fetch_mq
module tb_core_pipe_fetch_mq;
  import core_common::*;

  localparam logic [31:0] PC_RST = 32'h1000_0000;
  localparam int FB = 8, MAXO = 2, BUFB = 16, FH = FB / 2;

  logic g_clk = 1'b0, g_resetn = 1'b0;
  logic cf_valid = 1'b0, cf_ack;
  logic [31:0] cf_target = '0;
  logic imem_req, imem_gnt = 1'b0;
  logic [31:0] imem_addr;
  logic imem_wen;
  logic [MEM_STRB_W-1:0] imem_strb;
  logic [MEM_DATA_W-1:0] imem_wdata;
  logic imem_rsp = 1'b0, imem_err = 1'b0;
  logic [FB*8-1:0] imem_rdata = '0;
  logic s1_i16bit, s1_i32bit, s1_eat_2 = 1'b0, s1_eat_4 = 1'b0;
  logic [31:0] s1_instr;
  logic [1:0] s1_ferr;

  core_pipe_fetch_mq #(.PC_RESET_ADDRESS(PC_RST), .FETCH_BYTES(FB),
                       .MAX_OUTSTANDING(MAXO), .BUF_BYTES(BUFB)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn), .cf_valid(cf_valid), .cf_ack(cf_ack),
    .cf_target(cf_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_wdata(imem_wdata), .imem_rsp(imem_rsp), .imem_err(imem_err),
    .imem_rdata(imem_rdata), .s1_i16bit(s1_i16bit), .s1_i32bit(s1_i32bit),
    .s1_instr(s1_instr), .s1_ferr(s1_ferr), .s1_eat_2(s1_eat_2), .s1_eat_4(s1_eat_4));

  always #5 g_clk = ~g_clk;

  typedef struct { logic [31:0] addr; int ready; } mem_t;
  typedef struct { logic [31:0] addr; bit stale; } infl_t;
  mem_t  mem_q[$];
  infl_t infl[$];
  logic [16:0] mq[$];   // {err, halfword} expected fetch stream

  int n_checks = 0, n_err = 0;
  int cyc = 0, rst_edges = 0;
  int p_gnt, p_rsp, p_eat, p_cf;
  int n_eats = 0, n_cf = 0, off;
  bit cf_done = 0, first_fill = 1, prev_pend = 0, skip_req_chk = 1;
  logic [31:0] exp_addr = PC_RST, prev_addr, stream_off = 0;
  logic [31:0] e_instr;
  logic [1:0]  e_ferr;
  logic        e16, e32, e_req;
  infl_t       ent;

  function automatic logic [15:0] hw_of(input logic [31:0] a);
    logic [31:0] x;
    x = a * 32'h9E37_79B1;
    return x[31:16] ^ x[15:0];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge g_clk) rst_edges = g_resetn ? 0 : rst_edges + 1;

  // Monitor: compare outputs against the stream model, then apply this cycle's events.
  always @(negedge g_clk) begin
    if (!g_resetn) begin
      if (rst_edges > 0) begin
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, PC_RST);
        check("rst_i16", s1_i16bit, 0);
        check("rst_i32", s1_i32bit, 0);
        check("rst_tie", {imem_wen, imem_strb, imem_wdata}, 0);
      end
      mq.delete(); infl.delete();
      exp_addr = PC_RST; stream_off = 0; first_fill = 1;
      prev_pend = 0; skip_req_chk = 1;
    end else begin
      e_req = (infl.size() < MAXO) && (mq.size() * 2 + (infl.size() + 1) * FB <= BUFB);
      if (prev_pend) begin
        check("hold_req", imem_req, 1);
        check("hold_addr", imem_addr, prev_addr);
      end else if (!skip_req_chk) begin
        check("req_credit", imem_req, e_req);
      end
      skip_req_chk = 0;
      check("cf_ack", cf_ack, !imem_req || imem_gnt);
      e_instr = '0; e_ferr = '0; e16 = 0; e32 = 0;
      if (mq.size() >= 1) begin
        e_instr[15:0] = mq[0][15:0]; e_ferr[0] = mq[0][16];
        e16 = (mq[0][1:0] != 2'b11);
      end
      if (mq.size() >= 2) begin
        e_instr[31:16] = mq[1][15:0]; e_ferr[1] = mq[1][16];
        e32 = (mq[0][1:0] == 2'b11);
      end
      check("s1_i16bit", s1_i16bit, e16);
      check("s1_i32bit", s1_i32bit, e32);
      check("s1_instr", s1_instr, e_instr);
      check("s1_ferr", s1_ferr, e_ferr);
      // events, in order: grant, response, eat, cf (cf overrides the rest)
      if (imem_req && imem_gnt) begin
        check("grant_addr", imem_addr, exp_addr);
        infl.push_back('{addr: exp_addr, stale: 1'b0});
        mem_q.push_back('{addr: imem_addr, ready: cyc + 1});
        exp_addr = exp_addr + FB;
      end
      if (imem_rsp) begin
        if (infl.size() == 0) check("rsp_unowed", 1, 0);
        else begin
          ent = infl.pop_front();
          if (!ent.stale) begin
            off = first_fill ? int'(stream_off) : 0;
            first_fill = 0;
            for (int k = off / 2; k < FH; k++) mq.push_back({imem_err, hw_of(ent.addr + 2 * k)});
          end
        end
      end
      if (s1_eat_4 && mq.size() >= 2) begin void'(mq.pop_front()); void'(mq.pop_front()); n_eats++; end
      else if (s1_eat_2 && mq.size() >= 1) begin void'(mq.pop_front()); n_eats++; end
      if (cf_valid && cf_ack) begin
        foreach (infl[i]) infl[i].stale = 1'b1;
        mq.delete();
        exp_addr   = cf_target & ~32'(FB - 1);
        stream_off = cf_target & 32'(FB - 1);
        first_fill = 1; cf_done = 1; n_cf++;
      end
      prev_pend = imem_req && !imem_gnt;
      prev_addr = imem_addr;
    end
  end

  function automatic logic [31:0] pick_target();
    case ($urandom_range(3))
      0: return 32'h0000_2006;
      1: return 32'hFFFF_FFFA;
      2: return PC_RST + ($urandom_range(255) & ~32'h1);
      default: return $urandom & ~32'h1;
    endcase
  endfunction

  task automatic drive_cycle();
    logic [31:0] a;
    @(posedge g_clk); #1; cyc++;
    if (cf_done) begin cf_valid = 0; cf_done = 0; end
    imem_gnt = ($urandom_range(99) < p_gnt);
    imem_rsp = 0; imem_err = 0; imem_rdata = '0;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc && $urandom_range(99) < p_rsp) begin
      a = mem_q[0].addr; void'(mem_q.pop_front());
      imem_rsp = 1; imem_err = ($urandom_range(7) == 0);
      for (int k = 0; k < FH; k++) imem_rdata[16*k +: 16] = hw_of(a + 2 * k);
    end
    if (!cf_valid && $urandom_range(999) < p_cf) begin cf_valid = 1; cf_target = pick_target(); end
    s1_eat_2 = 0; s1_eat_4 = 0;
    if ($urandom_range(99) < p_eat) begin
      if (s1_i32bit) s1_eat_4 = 1;
      else if (s1_i16bit) s1_eat_2 = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge g_clk); #1;
    g_resetn = 0; cf_valid = 0; cf_done = 0; imem_gnt = 0; imem_rsp = 0; imem_err = 0;
    s1_eat_2 = 0; s1_eat_4 = 0; mem_q.delete();
    repeat (3) begin @(posedge g_clk); #1; end
    g_resetn = 1;
  endtask

  task automatic run_phase(input int n, input int g, input int r, input int e, input int c);
    p_gnt = g; p_rsp = r; p_eat = e; p_cf = c;
    repeat (n) drive_cycle();
  endtask

  initial begin
    do_reset();
    run_phase(30, 100, 100, 0, 0);     // streaming fetch, buffer saturates
    run_phase(1500, 70, 60, 60, 30);
    run_phase(500, 15, 50, 80, 100);   // long grant stalls with cf pressure
    do_reset();
    run_phase(1000, 90, 90, 90, 20);
    check("progress_eats", n_eats > 200, 1);
    check("progress_cf", n_cf > 5, 1);
    check("tie_zero", {imem_wen, imem_strb, imem_wdata}, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
